// File: rtl/score_pkg.sv
// score_pkg: shared game-state encoding, hit-size codes and default scoring constants.
package score_pkg;
   typedef enum logic [1:0] {IDLE, PLAY, DYING, OVER} game_state_t;
   localparam logic [1:0] SZ_SMALL = 2'd0, SZ_MED = 2'd1, SZ_LARGE = 2'd2, SZ_NONE = 2'd3;
   localparam int SCORE_W = 8;
   localparam int PTS_LARGE = 1, PTS_MED = 2, PTS_SMALL = 5;
   localparam int LIFE_STEP = 50, START_LIVES = 3, MAX_LIVES = 3;
   localparam int RESPAWN_FRAMES = 60, FIFO_DEPTH = 4;
endpackage

// File: rtl/hit_fifo.sv
// hit_fifo: small valid/ready queue for hit events; flush wins over a same-cycle push.
module hit_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic push, pop;
   assign in_ready  = cnt != (AW+1)'(DEPTH);
   assign out_valid = cnt != '0;
   assign out_data  = mem[rp];
   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push && !flush) mem[wp] <= in_data;
endmodule

// File: rtl/score_keeper.sv
// score_keeper: accumulates hit points, awards lives, runs the game FSM and
// publishes a frame-stable score to the HUD.
module score_keeper
   import score_pkg::*;
#(
   parameter int PTS_L = PTS_LARGE,
   parameter int PTS_M = PTS_MED,
   parameter int PTS_S = PTS_SMALL,
   parameter int STEP = LIFE_STEP,
   parameter int START_L = START_LIVES,
   parameter int MAX_L = MAX_LIVES,
   parameter int RESPAWN = RESPAWN_FRAMES,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       hit_valid,
   input  logic [1:0] hit_size,
   output logic       hit_ready,
   input  logic       ship_hit,
   output logic [7:0] score,
   output logic [7:0] high_score,
   output logic [1:0] lives,
   output logic [1:0] state,
   output logic       game_over,
   output logic       extra_life
);
   game_state_t st;
   logic [7:0] acc, acc_nx, pts, cnt;
   logic [8:0] sum, thr;
   logic [2:0] l3;
   logic [1:0] lives_nx, head;
   logic head_v, playing, pop, award, dec;
   assign state   = st;
   assign playing = st == PLAY || st == DYING;
   assign pop     = head_v & playing;
   // Outside PLAY/DYING the queue is held flushed, so offered events are consumed and dropped.
   hit_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
      .clk(clk), .rst(rst), .flush(!playing),
      .in_valid(hit_valid), .in_ready(hit_ready), .in_data(hit_size),
      .out_valid(head_v), .out_ready(playing), .out_data(head)
   );
   always_comb begin
      pts = head == SZ_SMALL ? 8'(PTS_S) : head == SZ_MED ? 8'(PTS_M) :
            head == SZ_LARGE ? 8'(PTS_L) : 8'd0;
      sum = {1'b0, acc} + {1'b0, pts};
      acc_nx = !pop ? acc : sum[8] ? 8'hff : sum[7:0];
      award = pop && {1'b0, acc_nx} >= thr;
      dec = st == PLAY && ship_hit;
      l3 = {1'b0, lives} + {2'b0, award} - {2'b0, dec};
      lives_nx = l3 > 3'(MAX_L) ? 2'(MAX_L) : l3[1:0];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st         <= IDLE;
         acc        <= '0;
         thr        <= 9'(STEP);
         lives      <= '0;
         cnt        <= '0;
         score      <= '0;
         high_score <= '0;
         game_over  <= 1'b0;
         extra_life <= 1'b0;
      end else begin
         extra_life <= award;
         if (frame_tick) score <= acc;
         if (playing) begin
            acc   <= acc_nx;
            lives <= lives_nx;
            if (award) thr <= thr + 9'(STEP);
         end
         if (!playing && start) begin
            st        <= PLAY;
            acc       <= '0;
            lives     <= 2'(START_L);
            thr       <= 9'(STEP);
            game_over <= 1'b0;
         end else if (dec) begin
            if (lives_nx == 2'd0) begin
               st        <= OVER;
               game_over <= 1'b1;
               if (acc_nx > high_score) high_score <= acc_nx;
            end else begin
               st  <= DYING;
               cnt <= '0;
            end
         end else if (st == DYING && frame_tick) begin
            if (cnt == 8'(RESPAWN - 1)) st <= PLAY;
            else cnt <= cnt + 8'd1;
         end
      end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench; a reference model predicts score, lives and awards.
module tb_score_keeper;
   logic clk = 0, rst = 1, frame_tick = 0, start = 0, hit_valid = 0, ship_hit = 0;
   logic [1:0] hit_size = 0;
   logic hit_ready, game_over, extra_life;
   logic [7:0] score, high_score;
   logic [1:0] lives, state;
   int n_chk = 0, n_pass = 0;
   int m_acc = 0, m_thr = 50, m_lives = 0;
   int exp_q[$];

   score_keeper dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
      .hit_valid(hit_valid), .hit_size(hit_size), .hit_ready(hit_ready),
      .ship_hit(ship_hit), .score(score), .high_score(high_score),
      .lives(lives), .state(state), .game_over(game_over), .extra_life(extra_life)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic int apply(input int sz);
      int p = sz == 0 ? 5 : sz == 1 ? 2 : sz == 2 ? 1 : 0;
      m_acc = m_acc + p > 255 ? 255 : m_acc + p;
      if (m_acc >= m_thr) begin
         m_thr += 50;
         m_lives = m_lives < 3 ? m_lives + 1 : 3;
         return 1;
      end
      return 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      step();
      frame_tick = 1;
      exp_q.push_back(m_acc);
      step();
      frame_tick = 0;
      check("score", score, exp_q.pop_front());
   endtask

   task automatic burst(input int sz, input int n);
      hit_valid = 1;
      hit_size = 2'(sz);
      for (int i = 0; i < n; i++) begin
         step();
         check("ready_burst", hit_ready, 1);
         void'(apply(sz));
      end
      hit_valid = 0;
      step();
   endtask

   task automatic hit_one(input int sz);
      int aw;
      hit_valid = 1;
      hit_size = 2'(sz);
      step();
      hit_valid = 0;
      aw = apply(sz);
      step();
      check("extra_life", extra_life, aw);
      check("lives_hit", lives, m_lives);
   endtask

   task automatic die();
      ship_hit = 1;
      step();
      ship_hit = 0;
      m_lives--;
      check("state_die", state, m_lives == 0 ? 3 : 2);
      check("lives_die", lives, m_lives);
   endtask

   task automatic respawn();
      for (int i = 0; i < 60; i++) begin
         frame();
         check("state_respawn", state, i == 59 ? 1 : 2);
      end
   endtask

   task automatic new_game(input logic with_hit);
      start = 1;
      hit_valid = with_hit;
      hit_size = 2'd0;
      step();
      start = 0;
      hit_valid = 0;
      m_acc = 0;
      m_thr = 50;
      m_lives = 3;
      check("state_start", state, 1);
      check("lives_start", lives, 3);
      check("game_over_start", game_over, 0);
   endtask

   initial begin
      repeat (2) step();
      check("rst_score", score, 0);
      check("rst_high", high_score, 0);
      check("rst_lives", lives, 0);
      check("rst_state", state, 0);
      check("rst_game_over", game_over, 0);
      check("rst_extra_life", extra_life, 0);
      check("rst_ready", hit_ready, 1);
      rst = 0;
      step();
      new_game(0);
      burst(0, 3);
      step();
      check("score_hold", score, 0);
      frame();
      check("lives_3", lives, 3);
      burst(2, 5);
      frame();
      // Frame tick lands in the pop cycle: score must show the pre-update accumulator.
      hit_valid = 1;
      hit_size = 2'd0;
      step();
      hit_valid = 0;
      frame_tick = 1;
      exp_q.push_back(m_acc);
      step();
      frame_tick = 0;
      check("score_frame_pop", score, exp_q.pop_front());
      void'(apply(0));
      burst(0, 4);
      burst(1, 1);
      burst(2, 1);
      frame();
      hit_one(0);
      frame();
      die();
      ship_hit = 1;
      step();
      ship_hit = 0;
      check("dying_ignore_state", state, 2);
      check("dying_ignore_lives", lives, 2);
      respawn();
      die();
      respawn();
      burst(0, 9);
      hit_one(0);
      burst(0, 29);
      hit_one(0);
      hit_one(0);
      hit_one(0);
      frame();
      die();
      respawn();
      die();
      respawn();
      die();
      check("game_over", game_over, 1);
      check("high_first", high_score, 255);
      hit_valid = 1;
      hit_size = 2'd0;
      step();
      hit_valid = 0;
      check("ready_over", hit_ready, 1);
      new_game(1);
      repeat (3) step();
      frame();
      burst(0, 3);
      frame();
      die();
      respawn();
      die();
      respawn();
      die();
      check("game_over_2", game_over, 1);
      check("high_kept", high_score, 255);
      new_game(0);
      frame();
      burst(0, 2);
      frame();
      die();
      repeat (3) step();
      #2 rst = 1;
      #1;
      check("mid_rst_state", state, 0);
      check("mid_rst_lives", lives, 0);
      check("mid_rst_score", score, 0);
      check("mid_rst_high", high_score, 0);
      check("mid_rst_game_over", game_over, 0);
      check("mid_rst_extra_life", extra_life, 0);
      check("mid_rst_ready", hit_ready, 1);
      step();
      rst = 0;
      step();
      check("post_rst_state", state, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
